// File: rtl/l1_refill_engine.sv
// L1 refill engine: turns one cache load miss into an 8-word burst line fetch, or one store
// into a single-word memory write. A watchdog aborts any transaction that stops making progress.
module l1_refill_engine #(
    parameter int unsigned BURST_WORDS    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        REQ_VALID,
    input  logic                        REQ_WRITE,
    input  logic [31:0]                 REQ_ADDR,
    input  logic [31:0]                 REQ_WDATA,
    output logic                        BUSY,
    output logic                        LINE_VALID,
    output logic [32*BURST_WORDS-1:0]   LINE_DATA,
    output logic [31:0]                 LINE_ADDR,
    output logic                        WR_DONE,
    output logic                        ERR,
    output logic                        MEM_VALID,
    output logic                        MEM_LOAD,
    output logic                        MEM_STORE,
    input  logic                        MEM_READY,
    output logic [31:0]                 MEM_WDATA,
    input  logic [31:0]                 MEM_RDATA,
    output logic                        MEM_ACK_ADDR,
    input  logic [3:0]                  MEM_ACK_DATA_MEM,
    output logic [3:0]                  MEM_ACK_DATA_L1
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned IdxW = $clog2(BURST_WORDS);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LastIdx = 4'(BURST_WORDS - 1);
    localparam logic [3:0] NoIdx = 4'hF;

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StBurst, StSdata, StDone} state_e;

    state_e                         state_q;
    logic [31:0]                    addr_q;
    logic [31:0]                    wdata_q;
    logic                           write_q;
    logic [BURST_WORDS-1:0][31:0]   line_q;
    logic [CntW-1:0]                wd_cnt_q;

    logic                           burst_hit;
    logic                           progress;
    logic                           wd_expire;

    // Progress detection per state; any progress clears the watchdog and suppresses the abort.
    always_comb begin
        burst_hit = (MEM_ACK_DATA_MEM == MEM_ACK_DATA_L1 + 4'd1) &&
                    (MEM_ACK_DATA_MEM <= LastIdx);
        progress  = 1'b0;
        case (state_q)
            StCmd:   progress = MEM_READY;
            StAddr:  progress = (MEM_ACK_DATA_MEM == 4'd0);
            StBurst: progress = burst_hit;
            StSdata: progress = !MEM_READY;
            StDone:  progress = 1'b1;
            default: progress = 1'b0;
        endcase
        wd_expire = (state_q != StIdle) && !progress && (wd_cnt_q == CntMax);
    end

    // Transaction FSM with registered outputs, line buffer and watchdog.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            wdata_q         <= '0;
            write_q         <= 1'b0;
            line_q          <= '0;
            wd_cnt_q        <= '0;
            BUSY            <= 1'b0;
            LINE_VALID      <= 1'b0;
            LINE_DATA       <= '0;
            LINE_ADDR       <= '0;
            WR_DONE         <= 1'b0;
            ERR             <= 1'b0;
            MEM_VALID       <= 1'b0;
            MEM_LOAD        <= 1'b0;
            MEM_STORE       <= 1'b0;
            MEM_WDATA       <= '0;
            MEM_ACK_ADDR    <= 1'b0;
            MEM_ACK_DATA_L1 <= NoIdx;
        end else begin
            LINE_VALID <= 1'b0;
            WR_DONE    <= 1'b0;
            ERR        <= 1'b0;
            if (state_q != StIdle) begin
                wd_cnt_q <= progress ? '0 : wd_cnt_q + CntW'(1);
            end
            case (state_q)
                StIdle: begin
                    if (REQ_VALID) begin
                        addr_q    <= REQ_WRITE ? REQ_ADDR : {REQ_ADDR[31:5], 5'b0};
                        wdata_q   <= REQ_WDATA;
                        write_q   <= REQ_WRITE;
                        line_q    <= '0;
                        wd_cnt_q  <= '0;
                        BUSY      <= 1'b1;
                        MEM_VALID <= 1'b1;
                        MEM_LOAD  <= !REQ_WRITE;
                        MEM_STORE <= REQ_WRITE;
                        state_q   <= StCmd;
                    end
                end
                StCmd: begin
                    if (MEM_READY) begin
                        MEM_WDATA    <= addr_q;
                        MEM_ACK_ADDR <= 1'b1;
                        state_q      <= StAddr;
                    end
                end
                StAddr: begin
                    if (MEM_ACK_DATA_MEM == 4'd0) begin
                        MEM_ACK_ADDR    <= 1'b0;
                        MEM_ACK_DATA_L1 <= 4'd0;
                        if (write_q) begin
                            MEM_WDATA <= wdata_q;
                            state_q   <= StSdata;
                        end else begin
                            line_q[0] <= MEM_RDATA;
                            state_q   <= StBurst;
                        end
                    end
                end
                StBurst: begin
                    // Only the next index in sequence is taken; repeats and skips are ignored.
                    if (burst_hit) begin
                        line_q[MEM_ACK_DATA_MEM[IdxW-1:0]] <= MEM_RDATA;
                        MEM_ACK_DATA_L1                    <= MEM_ACK_DATA_MEM;
                        if (MEM_ACK_DATA_MEM == LastIdx) begin
                            state_q <= StDone;
                        end
                    end
                end
                StSdata: begin
                    if (!MEM_READY) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    MEM_VALID       <= 1'b0;
                    MEM_LOAD        <= 1'b0;
                    MEM_STORE       <= 1'b0;
                    MEM_WDATA       <= '0;
                    MEM_ACK_DATA_L1 <= NoIdx;
                    BUSY            <= 1'b0;
                    if (write_q) begin
                        WR_DONE <= 1'b1;
                    end else begin
                        LINE_VALID <= 1'b1;
                        LINE_DATA  <= line_q;
                        LINE_ADDR  <= addr_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            // Watchdog abort overrides whatever the state above decided.
            if (wd_expire) begin
                ERR             <= 1'b1;
                BUSY            <= 1'b0;
                MEM_VALID       <= 1'b0;
                MEM_LOAD        <= 1'b0;
                MEM_STORE       <= 1'b0;
                MEM_WDATA       <= '0;
                MEM_ACK_ADDR    <= 1'b0;
                MEM_ACK_DATA_L1 <= NoIdx;
                state_q         <= StIdle;
            end
        end
    end

endmodule
